ram_port_arb: RTL
=================

Name: ram_port_arb

Overview:
- Round-robin arbiter that shares one port of the dual-port block RAM wrapper (CAddrLen/CDataLen RAM, registered address, unregistered q, read-enable-gated output) between CReqCnt requesters.
- Supports an optional locked burst per requester, capped at CBurstMax transfers.
- Sits between client engines (DMA, CPU data port, debug) and one RAM port.
- Drives the RAM port from registers and returns read data with a fixed 2-cycle latency.

Parameters:
- CReqCnt, 4, number of requesters (2..16)
- CAddrLen, 11, RAM address width
- CDataLen, 8, RAM data width
- CBurstMax, 8, max consecutive locked transfers per owner (>=1)

Ports:
- AClk  in  1  clock, shared with RAM port
- AReset  in  1  reset, asynchronous, active-high
- AReqAddr  in  CReqCnt*CAddrLen  flat per-requester address, requester i at [i*CAddrLen +: CAddrLen]
- AReqMosi  in  CReqCnt*CDataLen  flat per-requester write data
- AReqWr  in  CReqCnt  write request
- AReqRd  in  CReqCnt  read request
- AReqLock  in  CReqCnt  hold ownership after this transfer
- AAck  out  CReqCnt  one-hot grant; transfer occurs when (AReqWr|AReqRd)[i] & AAck[i]
- ARdVld  out  CReqCnt  one-hot read-data valid
- ARdData  out  CDataLen  read data, pass-through of AMemMiso
- AMemAddr  out  CAddrLen  RAM address
- AMemMosi  out  CDataLen  RAM write data
- AMemWrEn  out  1  RAM write enable
- AMemRdEn  out  1  RAM read enable
- AMemMiso  in  CDataLen  RAM read data

Behaviour:
- Clock and reset: single clock AClk. AReset is asynchronous and active-high. RAM clock enable is tied high by the integrator.
- Reset values: AMemAddr/AMemMosi = 0; AMemWrEn/AMemRdEn = 0; ARdVld = 0; state SArb; FLast = CReqCnt-1 (req0 highest priority first); burst count = 0.
- Request: Req[i] = AReqWr[i] | AReqRd[i]. Requester holds its request fields stable until it sees AAck[i].
- AAck: combinational from Req and registered state. At most one bit set. Zero when no eligible request.
- Read/write precedence: if AReqWr[i] and AReqRd[i] are both set, the write is performed and no ARdVld is issued.
- Timing, handshake in cycle t:
  - Edge t+1 registers the winner's addr, data, WrEn and RdEn onto AMem*. Cycle t+1 drives the RAM.
  - For a read, ARdVld[i] = 1 in cycle t+2, with ARdData = AMemMiso.
  - Registered one-hot tag pipeline: 2 stages.
  - Idle cycles drive AMemWrEn = AMemRdEn = 0. Address/data are held.
- Throughput: one transfer per cycle. Back-to-back grants to the same or different requesters are allowed.
- State SArb:
  - Winner = first i with Req[i], searching FLast+1 .. FLast+CReqCnt modulo CReqCnt.
  - On transfer: FLast = winner.
  - If AReqLock[winner] and CBurstMax > 1: go to SLock, owner = winner, count = 1.
- State SLock:
  - Only the owner is eligible; other requesters see AAck = 0.
  - Owner transfer: count++.
  - Exit to SArb after the transfer if AReqLock = 0, or if count reaches CBurstMax.
  - If owner Req = 0 for a cycle: no grant that cycle (one-cycle bubble), go to SArb.
  - On any exit: FLast = owner, so other requesters get priority next.
- Count width: clog2(CBurstMax+1). Count never exceeds CBurstMax. Count is cleared on SArb entry.
- FLast wraps from CReqCnt-1 to 0.
- Reset mid-operation:
  - In-flight reads are discarded; ARdVld stays 0.
  - A lock is released.
  - RAM contents are not touched, except that a write registered in the same cycle as the reset assertion is not guaranteed.
- Address ranges: no range checking. Addresses wrap within the RAM.

Decomposition:
- Shared include ram_arb_pkg holds:
  - state encodings SArb = 1'b0, SLock = 1'b1
  - a clog2 helper function
  - the flat-bus slice macros
- Sub-module rr_pick (combinational): inputs are the request vector and last-index; outputs are a one-hot winner and a binary index. It is instantiated once and reused by any future arbiter.

Test Plan:
1. Reset: assert AReset mid-cycle -> all outputs 0 immediately (async). First grant after release goes to req0 when all requesters are requesting.
2. Req0 write addr 0x005 data 0xA5, then read 0x005 -> AMemWrEn is high one cycle after the write ack. ARdVld[0] is high 2 cycles after the read ack with ARdData = 0xA5.
3. All four requesters continuously reading, no lock -> AAck sequence 0,1,2,3,0,1..., one per cycle. Each ARdVld follows its ack by 2 cycles.
4. Req2 locked reads with others requesting, CBurstMax = 8 -> 8 consecutive acks to req2, then 3, 0, 1, 2. Count never exceeds 8.
5. Req1 asserts AReqWr and AReqRd together, addr 0x010 data 0x3C -> a write occurs, no ARdVld[1]. A later read of 0x010 returns 0x3C.
6. Reset asserted one cycle after a read ack to req3 while req3 holds a lock -> ARdVld[3] never pulses, state returns to SArb, and after release req0 wins first.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM port arbiter: FSM encodings, clog2 helper
// and the flat-bus slice macro used to unpack per-requester fields.
`ifndef RAM_ARB_PKG_SV
`define RAM_ARB_PKG_SV

`define RAM_ARB_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

package ram_arb_pkg;

  typedef enum logic {
    SArb  = 1'b0,
    SLock = 1'b1
  } arbStateT;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

`endif

// File: rtl/ram_port_arb_rr_pick.sv
// Combinational round-robin picker: first requester after lastIdx wins,
// reported both one-hot and as a binary index.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int CReqCnt = 4,
  parameter int CIdxLen = 2
) (
  input  logic [CReqCnt-1:0] req,
  input  logic [CIdxLen-1:0] lastIdx,
  output logic [CReqCnt-1:0] grantOh,
  output logic [CIdxLen-1:0] grantIdx,
  output logic               grantVld
);

  int cand;

  always_comb begin
    grantOh  = '0;
    grantIdx = '0;
    grantVld = 1'b0;
    cand     = 0;
    // Scan lastIdx+1 .. lastIdx+CReqCnt so the previous winner is checked last.
    for (int off = 1; off <= CReqCnt; off++) begin
      cand = (int'(lastIdx) + off) % CReqCnt;
      if (!grantVld && req[cand]) begin
        grantVld      = 1'b1;
        grantOh[cand] = 1'b1;
        grantIdx      = CIdxLen'(cand);
      end
    end
  end

endmodule

// File: rtl/ram_port_arb.sv
// Round-robin arbiter sharing one block RAM port among CReqCnt requesters,
// with optional locked bursts and a fixed 2-cycle read-data return.
module ram_port_arb
  import ram_arb_pkg::*;
#(
  parameter int CReqCnt   = 4,
  parameter int CAddrLen  = 11,
  parameter int CDataLen  = 8,
  parameter int CBurstMax = 8
) (
  input  logic                         AClk,
  input  logic                         AReset,
  input  logic [CReqCnt*CAddrLen-1:0]  AReqAddr,
  input  logic [CReqCnt*CDataLen-1:0]  AReqMosi,
  input  logic [CReqCnt-1:0]           AReqWr,
  input  logic [CReqCnt-1:0]           AReqRd,
  input  logic [CReqCnt-1:0]           AReqLock,
  output logic [CReqCnt-1:0]           AAck,
  output logic [CReqCnt-1:0]           ARdVld,
  output logic [CDataLen-1:0]          ARdData,
  output logic [CAddrLen-1:0]          AMemAddr,
  output logic [CDataLen-1:0]          AMemMosi,
  output logic                         AMemWrEn,
  output logic                         AMemRdEn,
  input  logic [CDataLen-1:0]          AMemMiso
);

  localparam int CIdxLen = clog2(CReqCnt);
  localparam int CCntLen = clog2(CBurstMax + 1);

  logic [CAddrLen-1:0] reqAddr [CReqCnt];
  logic [CDataLen-1:0] reqMosi [CReqCnt];
  logic [CReqCnt-1:0]  req;

  generate
    for (genvar gi = 0; gi < CReqCnt; gi++) begin : gUnpack
      assign reqAddr[gi] = `RAM_ARB_SLICE(AReqAddr, gi, CAddrLen);
      assign reqMosi[gi] = `RAM_ARB_SLICE(AReqMosi, gi, CDataLen);
    end
  endgenerate

  assign req = AReqWr | AReqRd;

  arbStateT           stateReg;
  logic [CIdxLen-1:0] lastReg;
  logic [CIdxLen-1:0] ownerReg;
  logic [CCntLen-1:0] countReg;
  logic [CCntLen-1:0] countNext;
  logic [CReqCnt-1:0] tag1Reg;
  logic [CReqCnt-1:0] tag2Reg;

  logic [CReqCnt-1:0] pickOh;
  logic [CIdxLen-1:0] pickIdx;
  logic               pickVld;

  rr_pick #(
    .CReqCnt (CReqCnt),
    .CIdxLen (CIdxLen)
  ) uPick (
    .req      (req),
    .lastIdx  (lastReg),
    .grantOh  (pickOh),
    .grantIdx (pickIdx),
    .grantVld (pickVld)
  );

  logic [CReqCnt-1:0] ackOh;
  logic [CIdxLen-1:0] selIdx;
  logic               xfer;
  logic               selWr;
  logic               selRd;

  always_comb begin
    ackOh  = '0;
    selIdx = pickIdx;
    xfer   = 1'b0;
    if (stateReg == SArb) begin
      ackOh = pickOh;
      xfer  = pickVld;
    end else begin
      selIdx = ownerReg;
      if (req[ownerReg]) begin
        ackOh[ownerReg] = 1'b1;
        xfer            = 1'b1;
      end
    end
  end

  // A combined write+read request is treated purely as a write.
  assign selWr     = AReqWr[selIdx];
  assign selRd     = AReqRd[selIdx] & ~AReqWr[selIdx];
  assign countNext = countReg + CCntLen'(1);

  assign AAck    = ackOh;
  assign ARdVld  = tag2Reg;
  assign ARdData = AMemMiso;

  always_ff @(posedge AClk or posedge AReset) begin
    if (AReset) begin
      AMemAddr <= '0;
      AMemMosi <= '0;
      AMemWrEn <= 1'b0;
      AMemRdEn <= 1'b0;
      tag1Reg  <= '0;
      tag2Reg  <= '0;
    end else begin
      AMemWrEn <= xfer & selWr;
      AMemRdEn <= xfer & selRd;
      if (xfer) begin
        AMemAddr <= reqAddr[selIdx];
        AMemMosi <= reqMosi[selIdx];
      end
      tag1Reg <= (xfer && selRd) ? ackOh : '0;
      tag2Reg <= tag1Reg;
    end
  end

  always_ff @(posedge AClk or posedge AReset) begin
    if (AReset) begin
      stateReg <= SArb;
      lastReg  <= CIdxLen'(CReqCnt - 1);
      ownerReg <= '0;
      countReg <= '0;
    end else begin
      case (stateReg)
        SArb: begin
          if (pickVld) begin
            lastReg <= pickIdx;
            if (AReqLock[pickIdx] && (CBurstMax > 1)) begin
              stateReg <= SLock;
              ownerReg <= pickIdx;
              countReg <= CCntLen'(1);
            end
          end
        end
        SLock: begin
          // Every exit hands priority to the requester after the owner.
          if (req[ownerReg] && AReqLock[ownerReg] &&
              (countNext < CCntLen'(CBurstMax))) begin
            countReg <= countNext;
          end else begin
            stateReg <= SArb;
            lastReg  <= ownerReg;
            countReg <= '0;
          end
        end
        default: begin
          stateReg <= SArb;
          countReg <= '0;
        end
      endcase
    end
  end

endmodule
